// File: rtl/shared_write_arbiter.sv
// Single-writer front end for a shared register: NUM_REQ requesters, round-robin grant, bounded ownership.
// Build option: define ARB_FIXED_PRIO_EN to make the lowest-indexed requester always win.
module shared_write_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         shared_q,
  output logic                      shared_we,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;

  logic [IDX_W-1:0]  pick;
  logic              pick_vld;
  logic              owner_req;
  logic              owner_last;
  logic [DATA_W-1:0] owner_data;
  logic              release_now;

`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]  ptr_q, ptr_d;
`endif

  // Winner selection, only consulted while IDLE.
  always_comb begin : arb_pick
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
`ifdef ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && req[i]) begin
        pick     = IDX_W'(i);
        pick_vld = 1'b1;
      end
    end
`else
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!pick_vld && req[idx]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    owner_req   = req[owner_q];
    owner_last  = req_last[owner_q];
    owner_data  = req_data[int'(owner_q)*DATA_W +: DATA_W];
    // Terminal write (last marker or hold limit) and a dropped request both end the grant.
    release_now = !owner_req || owner_last || (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q      <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      data_q     <= data_d;
      we_q       <= we_d;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    data_d     = data_q;
    we_d       = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (pick_vld) begin
          state_d = OWN;
          owner_d = pick;
        end
      end
      OWN: begin
        if (owner_req) begin
          data_d     = owner_data;
          we_d       = 1'b1;
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (release_now) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
`ifndef ARB_FIXED_PRIO_EN
          ptr_d      = owner_q;
`endif
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    gnt       = '0;
    busy      = 1'b0;
    shared_q  = data_q;
    shared_we = we_q;
    case (state_q)
      OWN: begin
        gnt[owner_q] = 1'b1;
        busy         = 1'b1;
      end
      default: begin
        gnt  = '0;
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shared_write_arbiter.sv
// Directed plus randomized bench for shared_write_arbiter against a cycle-level ownership model.
module tb_shared_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [W-1:0]   shared_q;
  logic           shared_we;
  logic           busy;

  int checks = 0;
  int errors = 0;

  int       m_owner;
  int       m_cnt;
  int       m_ptr;
  logic [W-1:0] m_q;
  logic     m_we;
  logic     prev_busy;

  shared_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_HOLD(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .req_data(req_data),
    .gnt(gnt), .shared_q(shared_q), .shared_we(shared_we), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit fixed_prio();
`ifdef ARB_FIXED_PRIO_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    int o, found, cand;
    bit rel;
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_ptr = N - 1; m_q = '0; m_we = 1'b0;
    end else if (m_owner < 0) begin
      m_we  = 1'b0;
      found = -1;
      for (int k = 1; k <= N; k++) begin
        cand = fixed_prio() ? k - 1 : (m_ptr + k) % N;
        if (found < 0 && req[cand]) found = cand;
      end
      if (found >= 0) begin
        m_owner = found;
        m_cnt   = 0;
      end
    end else begin
      o   = m_owner;
      rel = !req[o] || req_last[o] || (m_cnt == H - 1);
      if (req[o]) begin
        m_q  = req_data[o*W +: W];
        m_we = 1'b1;
        m_cnt++;
      end else begin
        m_we = 1'b0;
      end
      if (rel) begin
        if (!fixed_prio()) m_ptr = o;
        m_owner = -1;
        m_cnt   = 0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    prev_busy = busy;
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("shared_we", 32'(shared_we), 32'(m_we));
    chk("shared_q", 32'(shared_q), 32'(m_q));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (shared_we) chk("we_after_busy", 32'(prev_busy), 32'd1);
  endtask

  function automatic int gidx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  initial begin
    int order[$];
    int pulses[$];
    int exp_order[5];
    int exp_alt;
    m_owner = -1; m_cnt = 0; m_ptr = N - 1; m_q = '0; m_we = 1'b0; prev_busy = 1'b0;

    // Reset held with everything requesting
    rst_n = 1'b0; req = '1; req_last = '0; req_data = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_q", 32'(shared_q), 32'h00);
    end

    // Fairness from reset: five full grants 0,1,2,3,0
    rst_n = 1'b1; req = '1;
    for (int c = 0; c < 25; c++) begin
      req_data = {$urandom, $urandom};
      step();
      if (busy && !prev_busy) begin
        order.push_back(gidx(gnt));
        pulses.push_back(0);
      end
      if (shared_we && pulses.size() > 0) pulses[pulses.size()-1]++;
    end
    req = '0;
    step();
    exp_order = '{0, 1, 2, 3, 0};
    chk("fair_ngrants", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      chk("fair_order", 32'(order[i]), 32'(fixed_prio() ? 0 : exp_order[i]));
      chk("fair_pulses", 32'(pulses[i]), 32'(H));
    end

    // Single requester, two writes ending with req_last
    req = 4'b0100; req_last = '0; req_data = '0; req_data[2*W +: W] = 8'hA5;
    step();
    chk("single_gnt", 32'(gnt), 32'b0100);
    step();
    chk("single_q1", 32'(shared_q), 32'hA5);
    req_data[2*W +: W] = 8'h3C; req_last = 4'b0100;
    step();
    chk("single_q2", 32'(shared_q), 32'h3C);
    chk("single_rel", 32'(gnt), 32'd0);
    req = '0; req_last = '0;
    step();
    chk("single_idle", 32'(busy), 32'd0);

    // Wrap: owner 3 releases, then 0 wins over 3
    req = 4'b1000; req_last = 4'b1000;
    step(); step();
    req = 4'b1001; req_last = '0;
    step();
    chk("wrap_gnt", 32'(gnt), fixed_prio() ? 32'b0001 : 32'b0001);
    req = '0;
    step();

    // Early drop by owner 1
    req = 4'b0010;
    step(); step();
    req = 4'b0101;
    step();
    chk("drop_rel", 32'(busy), 32'd0);
    chk("drop_we", 32'(shared_we), 32'd0);
    step();
    chk("drop_next", 32'(gnt), fixed_prio() ? 32'b0001 : 32'b0100);

    // Mid-ownership reset
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_q", 32'(shared_q), 32'd0);
    rst_n = 1'b1; req = '1;
    step();
    chk("midrst_first", 32'(gnt), 32'b0001);
    req = '0;
    for (int i = 0; i < 3; i++) step();

    // req=1010 held: fixed priority sticks to 1, round-robin alternates
    req = 4'b1010;
    exp_alt = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (busy && !prev_busy) begin
        chk("prio_gnt", 32'(gnt), 32'd1 << exp_alt);
        if (!fixed_prio()) exp_alt = (exp_alt == 1) ? 3 : 1;
      end
    end

    // Random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      rst_n    = ($urandom_range(49) != 0);
      req      = N'($urandom);
      req_last = N'($urandom & $urandom);
      req_data = {$urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
